three_operand_adder_pipe: RTL
=============================

Name: three_operand_adder_pipe

Overview:
Parametrised, pipelined successor to the team's 16-bit three-operand adder (carry-save row feeding a sparse parallel-prefix carry tree).
- Computes a+b+c+cin, or a+b−c, for any WIDTH.
- Latency is 3 cycles, with valid/ready handshakes on input and output.
- Sits between operand-fetch logic and the result writeback in the datapath and absorbs downstream stalls without dropping data.

Parameters:
WIDTH, 32, operand width in bits (≥4).
PREFIX_SPLIT, 0, prefix-tree level after which the stage-2/stage-3 register is placed; 0 = ceil(log2(WIDTH+2))/2.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set present
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
c  input  WIDTH  operand C, unsigned
cin  input  1  carry-in, ADD3 mode only
mode  input  1  0 = ADD3 (a+b+c+cin), 1 = SUBC (a+b−c)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH+2  result
busy  output  1  any pipeline stage holds valid data

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low.
- Reset: all stage valid bits = 0; out_valid = 0; busy = 0; sum = 0; in_ready = 1 once rst_n deasserts.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage S1 (CSA):
  - Zero-extend a, b, c to WIDTH+2 bits. In SUBC, replace c with its bitwise inverse, c' = ~c_ext (top two bits = 1), and force the carry-in to 1; cin is ignored.
  - Full-adder row gives sum vector Sx and carry vector cy (cy shifted left 1, LSB = carry-in).
  - Register Sx, cy and mode.
- Stage S2: per-bit P = Sx^cy_shifted and G = Sx&cy_shifted, then prefix levels 1..PREFIX_SPLIT. Register the partial G/P.
- Stage S3: remaining prefix levels, then sum[i] = P[i] ^ Gcarry[i-1], with sum[0] = P[0]. Register sum and out_valid.
- Result is modulo 2^(WIDTH+2):
  - ADD3 result is exact (max 3·(2^W−1)+1).
  - SUBC result is the exact two's-complement value in WIDTH+2 bits.
- Latency: 3 cycles from input transfer to out_valid when out_ready is held at 1. Throughput is 1 per cycle.
- Flow control:
  - Stage k advances when it is valid and (stage k+1 is empty, or stage k+1 advances).
  - S3 advances on out_ready.
  - in_ready = !S1.valid || S1.advances. The combinational ready chain is permitted.
- Stall: with out_ready=0 and all stages full, in_ready=0 and sum/out_valid hold stable.
- Bubbles collapse: an empty stage is filled even while downstream stalls.
- Simultaneous input and output transfer in the same cycle: both complete, and occupancy is unchanged.
- Mid-operation reset: in-flight data is discarded immediately (asynchronous). No result for pre-reset inputs ever appears.
- busy = S1.v | S2.v | S3.v.
- No X on sum when out_valid=0; sum holds its last value.

Decomposition:
- Package three_op_pkg holds:
  - the mode constants MODE_ADD3 = 0 and MODE_SUBC = 1;
  - the function computing the default PREFIX_SPLIT;
  - the typedef of the per-stage G/P bundle.
- One sub-module, csa_row: a parametrised WIDTH+2 full-adder row with optional inversion of c.
- The prefix tree is generated inline with generate loops (black/grey-cell equations).

Test Plan:
1. WIDTH=16, mode=0, a=b=c=0xFFFF, cin=1, out_ready=1 -> sum=0x2FFFE, out_valid exactly 3 cycles after the accept.
2. WIDTH=16, mode=1, a=5, b=7, c=3, cin=1 (ignored) -> sum=0x00009. Then a=0, b=0, c=1 -> sum=0x3FFFF (−1).
3. Back-to-back stream of 100 random ADD3/SUBC vectors, out_ready=1 -> one result per cycle, in order, matching the reference model.
4. Backpressure: out_ready=0 for 6 cycles after 5 accepts -> in_ready drops after the 3rd accept. Held sum is stable. On release, results drain in order with no loss or duplication.
5. Random in_valid/out_ready toggling over 2000 cycles -> scoreboard match, and busy=0 only when all stages are empty.
6. Assert rst_n=0 mid-stream with 3 items in flight -> out_valid=0 and busy=0 immediately. After release, the first result corresponds to the first post-reset input.

Source files
------------

// File: rtl/three_operand_adder_pipe_pkg.sv
// three_op_pkg: shared mode constants, prefix-split default and G/P cell type for the three-operand adder
package three_op_pkg;
    localparam logic MODE_ADD3 = 1'b0;
    localparam logic MODE_SUBC = 1'b1;
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;
    function automatic int default_split(input int width);
        return $clog2(width + 2) / 2;
    endfunction
endpackage

// File: rtl/three_operand_adder_pipe_csa_row.sv
// csa_row: carry-save full-adder row over three operands with optional inversion of c for subtraction
module csa_row #(
    parameter int N = 34
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic         inv,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic [N-1:0] cy
);
    logic [N-1:0] cc;
    assign cc = inv ? ~c : c;
    assign s  = a ^ b ^ cc;
    // subtraction needs the +1 of two's complement, which takes the carry-in slot
    assign cy = {(a[N-2:0] & b[N-2:0]) | (a[N-2:0] & cc[N-2:0]) | (b[N-2:0] & cc[N-2:0]), inv | cin};
endmodule

// File: rtl/three_operand_adder_pipe.sv
// three_operand_adder_pipe: 3-stage a+b+c+cin / a+b-c adder with carry-save row, split prefix tree and valid/ready flow
module three_operand_adder_pipe
    import three_op_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PREFIX_SPLIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy
);
    localparam int N   = WIDTH + 2;
    localparam int L   = $clog2(N);
    localparam int SPR = PREFIX_SPLIT == 0 ? default_split(WIDTH) : PREFIX_SPLIT;
    localparam int SP  = SPR > L ? L : SPR;
    logic v1, v2, v3, acc1, adv1, adv2, adv3;
    logic [N-1:0] sx, cy, s1_s, s1_c, s2_p, p0, gc;
    gp_t [N-1:0] s2_gp;
    gp_t [N-1:0] t [0:L];
    gp_t [N-1:0] u [0:L];
    assign adv3      = v3 & out_ready;
    assign adv2      = v2 & (~v3 | adv3);
    assign adv1      = v1 & (~v2 | adv2);
    assign in_ready  = ~v1 | adv1;
    assign acc1      = in_valid & in_ready;
    assign out_valid = v3;
    assign busy      = v1 | v2 | v3;
    csa_row #(.N(N)) u_csa (
        .a  ({2'b00, a}),
        .b  ({2'b00, b}),
        .c  ({2'b00, c}),
        .inv(mode == MODE_SUBC),
        .cin(cin),
        .s  (sx),
        .cy (cy)
    );
    for (genvar i = 0; i < N; i++) begin : g_gp
        assign t[0][i] = {s1_s[i] & s1_c[i], s1_s[i] ^ s1_c[i]};
    end
    // level SP takes its input from the stage-2 register instead of the combinational tree
    for (genvar l = 0; l <= L; l++) begin : g_src
        assign u[l] = (l == SP) ? s2_gp : t[l];
    end
    for (genvar l = 0; l < L; l++) begin : g_lvl
        for (genvar i = 0; i < N; i++) begin : g_cell
            if (i >= 2 ** l) begin : g_op
                assign t[l+1][i] = {u[l][i].g | (u[l][i].p & u[l][i-2**l].g), u[l][i].p & u[l][i-2**l].p};
            end else begin : g_pass
                assign t[l+1][i] = u[l][i];
            end
        end
    end
    always_comb begin
        p0 = '0;
        gc = '0;
        for (int i = 0; i < N; i++) begin
            p0[i] = t[0][i].p;
            gc[i] = u[L][i].g;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            s1_s  <= '0;
            s1_c  <= '0;
            s2_p  <= '0;
            s2_gp <= '0;
            sum   <= '0;
        end else begin
            v1 <= acc1 | (v1 & ~adv1);
            v2 <= adv1 | (v2 & ~adv2);
            v3 <= adv2 | (v3 & ~adv3);
            if (acc1) begin
                s1_s <= sx;
                s1_c <= cy;
            end
            if (adv1) begin
                s2_p  <= p0;
                s2_gp <= t[SP];
            end
            if (adv2) sum <= s2_p ^ (gc << 1);
        end
    end
endmodule
